// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver that holds the last correctly framed byte
// on cmd for the waveform-parameter selector, with valid/error strobes.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_cmd_rx: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q, rxs_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             tick_c;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_d_q   <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      rxs_d_q   <= rxs_q;
    end
  end

  // Sample point: mid start bit in START, one full bit period in DATA/STOP
  always_comb begin
    tick_c = 1'b0;
    case (state_q)
      S_START:        tick_c = (cnt_q == CNT_W'(HALF_BIT - 1));
      S_DATA, S_STOP: tick_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
      default:        tick_c = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (rxs_d_q && !rxs_q)            state_d = S_START;
      S_START:     if (tick_c)                       state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:      if (tick_c && bit_idx_q == 3'd7)  state_d = S_STOP;
      S_STOP:      if (tick_c)                       state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxs_q)                        state_d = S_IDLE;
      default:                                       state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; counter restarts on each sample and state change
  always_comb begin
    cnt_d       = '0;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_q != S_IDLE);
    if ((state_q == S_START || state_q == S_DATA || state_q == S_STOP) &&
        (state_d == state_q) && !tick_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      S_START: if (tick_c) bit_idx_d = 3'd0;
      S_DATA: begin
        if (tick_c) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (rxs_q) begin
            cmd_d       = shift_q;
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Testbench for uart_cmd_rx with N=16 clocks per bit.
module tb_uart_cmd_rx;

  localparam int N         = 16;
  localparam int HALF      = N / 2;
  localparam int PULSE_LAT = 2 + HALF + 9 * N;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [7:0]  data;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         inv_bad = 0;
  logic [7:0] exp_cmd = 8'h00;
  logic [7:0] prev_cmd = 8'h00;
  logic       prev_valid = 1'b0;
  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        mon_ev;

  uart_cmd_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder and strobe invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cmd   = cmd;
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid) begin
        mon_ev.cyc = 32'(cyc); mon_ev.err = 1'b0; mon_ev.data = cmd;
        obs_q.push_back(mon_ev);
      end
      if (frame_err) begin
        mon_ev.cyc = 32'(cyc); mon_ev.err = 1'b1; mon_ev.data = cmd;
        obs_q.push_back(mon_ev);
      end
      if (cmd_valid && frame_err) inv_bad++;
      if (cmd !== prev_cmd && !cmd_valid) inv_bad++;
      if (cmd_valid && prev_valid) inv_bad++;
      prev_cmd   = cmd;
      prev_valid = cmd_valid;
    end
  end

  // Line level seen by a sample taken 'off' cycles after E+2 for bit period p
  function automatic logic line_level(input logic [9:0] bits, input int p, input int off);
    int b;
    b = off / p;
    if (b <= 9) return bits[b];
    return 1'b1;
  endfunction

  // Reference: sample the frame at the nominal sample instants, predict the strobe
  function automatic void predict(input logic [7:0] d, input logic stop, input int p, input int e);
    logic [9:0] bits;
    logic [7:0] got;
    logic       st;
    ev_t        ev;
    bits = {stop, d, 1'b0};
    got  = 8'h00;
    if (line_level(bits, p, HALF) == 1'b1) return;
    for (int j = 0; j < 8; j++) got[j] = line_level(bits, p, HALF + N * (j + 1));
    st = line_level(bits, p, HALF + 9 * N);
    if (st) exp_cmd = got;
    ev.cyc  = 32'(e + PULSE_LAT);
    ev.err  = !st;
    ev.data = exp_cmd;
    exp_q.push_back(ev);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p, output int e);
    rx = 1'b0;
    e  = cyc + 1;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
  endtask

  task automatic line_idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    rx    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %02h want 00", cmd); end
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    n_tests++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL post_reset_cmd: got %02h want 00", cmd); end
    exp_cmd = 8'h00;
  endtask

  task automatic test_single();
    int e;
    obs_q.delete();
    send_frame(8'h31, 1'b1, N, e);
    line_idle(20);
    n_tests++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_tests++;
      if (obs_q[0].cyc !== 32'(e + 154) || obs_q[0].err !== 1'b0 || obs_q[0].data !== 8'h31) begin
        n_fail++;
        $display("FAIL single_event: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=0 cmd=31",
                 obs_q[0].cyc, obs_q[0].err, obs_q[0].data, e + 154);
      end
    end
    n_tests++; if (cmd !== 8'h31) begin n_fail++; $display("FAIL single_cmd_held: got %02h want 31", cmd); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
    exp_cmd = 8'h31;
  endtask

  task automatic test_back_to_back();
    int         e0, e1, e2;
    logic [7:0] want [3];
    want[0] = 8'h32; want[1] = 8'h34; want[2] = 8'h30;
    obs_q.delete();
    send_frame(want[0], 1'b1, N, e0);
    send_frame(want[1], 1'b1, N, e1);
    send_frame(want[2], 1'b1, N, e2);
    line_idle(20);
    n_tests++;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].cyc !== 32'(e0 + 154 + 160 * i) || obs_q[i].err !== 1'b0 || obs_q[i].data !== want[i]) begin
        n_fail++;
        $display("FAIL b2b_ev%0d: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=0 cmd=%02h",
                 i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, e0 + 154 + 160 * i, want[i]);
      end
    end
    exp_cmd = 8'h30;
  endtask

  task automatic test_start_glitch();
    int e, e2;
    obs_q.delete();
    exp_q.delete();
    rx = 1'b0;
    e  = cyc + 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cyc == e + 4) rx = 1'b1;
      if (cyc == e + 2) begin n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_e2: got %b want 0", busy); end end
      if (cyc == e + 3) begin n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_e3: got %b want 1", busy); end end
      if (cyc == e + 10) begin n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_e10: got %b want 1", busy); end end
      if (cyc == e + 11) begin n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_e11: got %b want 0", busy); end end
    end
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", obs_q.size()); end
    n_tests++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL glitch_cmd: got %02h want %02h", cmd, exp_cmd); end
    send_frame(8'h33, 1'b1, N, e2);
    predict(8'h33, 1'b1, N, e2);
    line_idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_ev_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL glitch_ev%0d: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=%b cmd=%02h",
                 i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
  endtask

  task automatic test_frame_err();
    int e, e2;
    obs_q.delete();
    exp_q.delete();
    send_frame(8'h55, 1'b0, N, e);
    predict(8'h55, 1'b0, N, e);
    repeat (40) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low_line: got %b want 1", busy); end
    rx = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cyc == e + 202) begin n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_e202: got %b want 1", busy); end end
      if (cyc == e + 203) begin n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_e203: got %b want 0", busy); end end
    end
    n_tests++; if (cmd !== 8'h33) begin n_fail++; $display("FAIL ferr_cmd_kept: got %02h want 33", cmd); end
    send_frame(8'h34, 1'b1, N, e2);
    predict(8'h34, 1'b1, N, e2);
    line_idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ferr_ev_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ferr_ev%0d: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=%b cmd=%02h",
                 i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int         e;
    logic [7:0] d;
    d = 8'hA5;
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = d[4];
    repeat (HALF) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL rstmid_cmd: got %02h want 00", cmd); end
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_valid: got %b want 0", cmd_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    exp_cmd = 8'h00;
    obs_q.delete();
    exp_q.delete();
    line_idle(5);
    send_frame(8'h31, 1'b1, N, e);
    predict(8'h31, 1'b1, N, e);
    line_idle(20);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_ev_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_ev%0d: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=%b cmd=%02h",
                 i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
  endtask

  task automatic test_baud_skew();
    int e;
    int n_valid;
    obs_q.delete();
    exp_q.delete();
    send_frame(8'hC3, 1'b1, 15, e);
    predict(8'hC3, 1'b1, 15, e);
    line_idle(20);
    send_frame(8'hC3, 1'b1, 17, e);
    predict(8'hC3, 1'b1, 17, e);
    line_idle(20);
    n_valid = 0;
    foreach (obs_q[i]) if (!obs_q[i].err && obs_q[i].data == 8'hC3) n_valid++;
    n_tests++; if (n_valid != 2) begin n_fail++; $display("FAIL skew_valid_count: got %0d want 2", n_valid); end
    n_tests++; if (cmd !== 8'hC3) begin n_fail++; $display("FAIL skew_cmd: got %02h want c3", cmd); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL skew_ev_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL skew_ev%0d: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=%b cmd=%02h",
                 i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random_frames();
    int         e, p, r, gap;
    logic       stop;
    logic [7:0] d;
    obs_q.delete();
    exp_q.delete();
    for (int f = 0; f < 12; f++) begin
      d = 8'($urandom);
      r = $urandom_range(0, 7);
      p = (r == 0) ? 15 : (r == 1) ? 17 : N;
      stop = (p != N) ? 1'b1 : ($urandom_range(0, 4) != 0);
      gap  = (p != N || !stop) ? $urandom_range(6, 15) : $urandom_range(0, 2);
      send_frame(d, stop, p, e);
      predict(d, stop, p, e);
      if (gap > 0) line_idle(gap);
    end
    line_idle(30);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_ev_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_ev%0d: got cyc=%0d err=%b cmd=%02h want cyc=%0d err=%b cmd=%02h",
                 i, obs_q[i].cyc, obs_q[i].err, obs_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    n_tests++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL rand_cmd_final: got %02h want %02h", cmd, exp_cmd); end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (inv_bad != 0) begin n_fail++; $display("FAIL strobe_invariants: got %0d violations want 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_frame_err();
    test_reset_mid();
    test_baud_skew();
    test_random_frames();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver for the AWG front end. It deserialises 8N1 UART frames from the host line and presents the last good byte on `cmd`, held between frames. `cmd` is the level-held command byte consumed by the waveform-parameter selector, which decodes ASCII '0'..'4' into frequency and amplitude settings. A one-cycle `cmd_valid` strobe and a `frame_err` strobe accompany each completed frame.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (derived, localparam): clocks per bit, N. N < 4 is an elaboration error.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `rx`, input, 1: asynchronous UART line. Idle high.
- `cmd`, output, 8: last correctly framed byte. Held until the next good frame.
- `cmd_valid`, output, 1: one-cycle pulse in the cycle `cmd` takes a new value.
- `frame_err`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rxs` and its previous value `rxs_d`, which also resets to 1.
- **Counters.** The bit-timing counter is `$clog2(N)` bits wide and clears on every state change. The bit index is 3 bits. The shift register is 8 bits and shifts right: each new sample enters at bit 7, so the frame is LSB first.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** on `rxs_d==1 && rxs==0`, go to START.
  - **START:** count to N/2−1 (integer division), then sample `rxs`.
    - Sample 0: go to DATA with bit index 0.
    - Sample 1: treat it as a glitch and return to IDLE with no output pulse.
  - **DATA:** count to N−1, then sample `rxs` into the shift register and increment the bit index. After index 7 is sampled, go to STOP.
  - **STOP:** count to N−1, then sample `rxs`.
    - Sample 1: load `cmd` from the shift register, pulse `cmd_valid`, and go to IDLE. The FSM returns to IDLE at mid-stop-bit, so back-to-back frames are accepted.
    - Sample 0: pulse `frame_err`, leave `cmd` unchanged, and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rxs==1`, then go to IDLE. A break or stuck-low line therefore yields exactly one `frame_err`, not repeated frames.
- **Output values.** All byte values 0x00–0xFF are passed through; no ASCII filtering. `cmd` is only written on a good stop bit.
- **Reset values:** `cmd`=8'h00, `cmd_valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters and shift register 0. 8'h00 is not a selector command, so the downstream parameters keep their defaults after reset.
- **Reset mid-frame:** the partial frame is discarded, all outputs return to their reset values, and no pulse is emitted.
- **Line held low at reset release:** the synchroniser reads 1 then 0, so a falling edge is detected. The frame samples as 0x00 with a low stop bit, giving one `frame_err`, then WAIT_HIGH. This is the required behaviour.

## Timing
- Define E as the first `clk` edge at which `rx` is captured low by synchroniser flop 1.
  - `rxs` goes low after edge E+1.
  - START is entered after edge E+2.
  - START sample occurs after N/2 further cycles.
  - Each DATA sample and the STOP sample follow at intervals of N cycles.
- `cmd_valid` and the new `cmd` are visible together after edge E+2+N/2+9N. `cmd_valid` is high for exactly one cycle.
- `frame_err` has the same timing as `cmd_valid`. `cmd_valid` and `frame_err` are never high together.
- `busy` rises the cycle after START is entered and falls the cycle after the FSM returns to IDLE.
- Tolerance: the sample point drifts by at most ±1 clock per bit from integer truncation of N. This gives correct reception for up to ±2% baud mismatch at N ≥ 16.

## Test plan
Benches use `CLK_FREQ=16`, `BAUD=1`, so N=16.
1. **Single frame.** Send 0x31 ('1') with a valid stop bit. Require `cmd`=0x31 and `cmd_valid` for one cycle at E+2+8+144=E+154, `frame_err`=0, and `busy` low afterwards.
2. **Back-to-back frames.** Send 0x32, 0x34, 0x30 with no idle gap. Require three `cmd_valid` pulses 160 cycles apart, with `cmd` sequence 0x32, 0x34, 0x30.
3. **Start glitch.** Drive `rx` low for 5 cycles, then high. Require a return to IDLE, no pulses, `cmd` unchanged, then a following 0x33 frame received correctly.
4. **Framing error.** Send 0x55 with stop bit 0, hold low 40 cycles, then release high. Require exactly one `frame_err` pulse, `cmd` keeping its prior value, `busy` high until `rxs` returns high, then a 0x34 frame accepted.
5. **Reset mid-frame.** Assert `rst_n` low after DATA bit 3 of 0xA5. Require `cmd`=0x00 and all pulses 0 immediately, asynchronously. After release with the line idle, a 0x31 frame is received.
6. **Baud skew.** Send 0xC3 with the bit period at 15 and then 17 clocks. Require `cmd`=0xC3 and `cmd_valid` in both cases.
